// File: rtl/core_pkg.sv
// Shared core definitions: writeback source indices and the writeback request payload.
package core_pkg;

  localparam int CORE_XLEN   = 32;
  localparam int CORE_REG_AW = 5;

  localparam int WB_SRC_PIPE = 0;
  localparam int WB_SRC_MUL  = 1;
  localparam int WB_SRC_FPU  = 2;
  localparam int WB_SRC_CSR  = 3;

  typedef struct packed {
    logic [CORE_REG_AW-1:0] rd_addr;
    logic [CORE_XLEN-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/core_rr_picker.sv
// Combinational round-robin picker over sources 1..NUM-1, searching from ptr with wrap.
module core_rr_picker #(
  parameter int NUM = 4
) (
  input  logic [NUM-1:0]         req,
  input  logic [$clog2(NUM)-1:0] ptr,
  output logic [NUM-1:0]         grant
);

  int   start;
  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    // Out-of-range pointer values never occur in practice; treat them as 1.
    start = (int'(ptr) == 0 || int'(ptr) >= NUM) ? 1 : int'(ptr);
    for (int i = 0; i < NUM - 1; i++) begin
      idx = ((start - 1 + i) % (NUM - 1)) + 1;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/core_wb_arbiter.sv
// Register-file write-port arbiter: pipeline first, multi-cycle units round-robin,
// with a starvation guard that preempts the pipeline. Output is registered.
module core_wb_arbiter
  import core_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REQ  = 4,
  parameter int REG_AW   = 5,
  parameter int MAX_WAIT = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  output logic [NUM_REQ-1:0]         o_req_ready,
  input  logic [NUM_REQ*REG_AW-1:0]  i_req_rd_addr,
  input  logic [NUM_REQ*XLEN-1:0]    i_req_data,
  input  logic                       i_hold,
  output logic                       o_stall_pipe,
  output logic                       o_rf_we,
  output logic [REG_AW-1:0]          o_rf_waddr,
  output logic [XLEN-1:0]            o_rf_wdata,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_id
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0]      wait_cnt [1:NUM_REQ-1];
  logic [GW-1:0]      rr_ptr;
  logic [NUM_REQ-1:0] starved;
  logic [NUM_REQ-1:0] others;
  logic [NUM_REQ-1:0] g_starved;
  logic [NUM_REQ-1:0] g_other;
  logic [NUM_REQ-1:0] grant;
  logic [GW-1:0]      grant_idx;
  logic [REG_AW-1:0]  sel_addr;
  logic [XLEN-1:0]    sel_data;

  always_comb begin
    starved = '0;
    others  = i_req_valid;
    others[WB_SRC_PIPE] = 1'b0;
    for (int k = 1; k < NUM_REQ; k++) begin
      starved[k] = i_req_valid[k] && (wait_cnt[k] == CW'(MAX_WAIT));
    end
  end

  core_rr_picker #(.NUM(NUM_REQ)) u_pick_starved (
    .req   (starved),
    .ptr   (rr_ptr),
    .grant (g_starved)
  );

  core_rr_picker #(.NUM(NUM_REQ)) u_pick_other (
    .req   (others),
    .ptr   (rr_ptr),
    .grant (g_other)
  );

  always_comb begin
    grant        = '0;
    o_stall_pipe = 1'b0;
    if (!i_hold) begin
      if (|starved) begin
        grant        = g_starved;
        o_stall_pipe = i_req_valid[WB_SRC_PIPE];
      end else if (i_req_valid[WB_SRC_PIPE]) begin
        grant[WB_SRC_PIPE] = 1'b1;
      end else begin
        grant = g_other;
      end
    end
  end

  assign o_req_ready = grant;

  always_comb begin
    grant_idx = '0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        grant_idx = GW'(k);
        sel_addr  = i_req_rd_addr[k*REG_AW +: REG_AW];
        sel_data  = i_req_data[k*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_rf_we    <= 1'b0;
      o_rf_waddr <= '0;
      o_rf_wdata <= '0;
      o_grant_id <= '0;
      rr_ptr     <= GW'(1);
      for (int k = 1; k < NUM_REQ; k++) wait_cnt[k] <= '0;
    end else begin
      o_rf_we <= 1'b0;
      if (|grant) begin
        // Writes to x0 still consume the grant but never reach the register file.
        o_rf_we    <= (sel_addr != '0);
        o_rf_waddr <= sel_addr;
        o_rf_wdata <= sel_data;
        o_grant_id <= grant_idx;
        if (grant_idx != GW'(WB_SRC_PIPE)) begin
          rr_ptr <= (grant_idx == GW'(NUM_REQ - 1)) ? GW'(1) : grant_idx + GW'(1);
        end
      end
      for (int k = 1; k < NUM_REQ; k++) begin
        if (!i_req_valid[k] || grant[k]) begin
          wait_cnt[k] <= '0;
        end else if (wait_cnt[k] != CW'(MAX_WAIT)) begin
          wait_cnt[k] <= wait_cnt[k] + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_core_wb_arbiter.sv
// Directed-vector bench for core_wb_arbiter; a driver queues expected per-cycle results,
// an independent monitor pops and compares them against the DUT each falling edge.
module tb_core_wb_arbiter;
  import core_pkg::*;

  typedef struct {
    logic        chk_rdy;
    logic [3:0]  rdy;
    logic        stall;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  gid;
    logic        dat_known;
  } rec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   valid;
  logic         hold;
  wb_req_t      reqs [4];
  logic [19:0]  rd_flat;
  logic [127:0] data_flat;

  logic [3:0]   ready;
  logic         stall;
  logic         rf_we;
  logic [4:0]   rf_waddr;
  logic [31:0]  rf_wdata;
  logic [1:0]   grant_id;

  rec_t q [$];
  rec_t mr;
  int   n_chk  = 0;
  int   n_fail = 0;

  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic [1:0]  m_gid;
  logic        m_known;

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rd_flat[k*5 +: 5]     = reqs[k].rd_addr;
      data_flat[k*32 +: 32] = reqs[k].data;
    end
  end

  core_wb_arbiter #(
    .XLEN(32), .NUM_REQ(4), .REG_AW(5), .MAX_WAIT(8)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_req_valid   (valid),
    .o_req_ready   (ready),
    .i_req_rd_addr (rd_flat),
    .i_req_data    (data_flat),
    .i_hold        (hold),
    .o_stall_pipe  (stall),
    .o_rf_we       (rf_we),
    .o_rf_waddr    (rf_waddr),
    .o_rf_wdata    (rf_wdata),
    .o_grant_id    (grant_id)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      mr = q.pop_front();
      if (mr.chk_rdy) begin
        check("ready", 64'(ready), 64'(mr.rdy));
        check("stall", 64'(stall), 64'(mr.stall));
      end
      check("rf_we", 64'(rf_we), 64'(mr.we));
      check("grant_id", 64'(grant_id), 64'(mr.gid));
      if (mr.dat_known) begin
        check("rf_waddr", 64'(rf_waddr), 64'(mr.waddr));
        check("rf_wdata", 64'(rf_wdata), 64'(mr.wdata));
      end
    end
  end

  task automatic push_rec(input logic chk, input logic [3:0] er, input logic es);
    rec_t r;
    r.chk_rdy   = chk;
    r.rdy       = er;
    r.stall     = es;
    r.we        = m_we;
    r.waddr     = m_waddr;
    r.wdata     = m_wdata;
    r.gid       = m_gid;
    r.dat_known = m_known;
    q.push_back(r);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_gid = '0; m_known = 1'b1;
    push_rec(1'b0, 4'b0000, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Drive one cycle; er/es are the hand-derived ready and stall for this cycle.
  task automatic step(input logic [3:0] v, input logic h, input logic [3:0] er, input logic es);
    int idx;
    valid = v;
    hold  = h;
    push_rec(1'b1, er, es);
    if (er != 4'b0000) begin
      idx = 0;
      for (int k = 0; k < 4; k++) if (er[k]) idx = k;
      m_gid = 2'(idx);
      if (reqs[idx].rd_addr != 5'd0) begin
        m_we = 1'b1; m_waddr = reqs[idx].rd_addr; m_wdata = reqs[idx].data; m_known = 1'b1;
      end else begin
        m_we = 1'b0; m_known = 1'b0;
      end
    end else begin
      m_we = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    valid = 4'b1111;
    hold  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      reqs[k].rd_addr = 5'(10 + k);
      reqs[k].data    = 32'hA000_0000 | 32'(k);
    end

    // Reset with every source requesting, then the first arbitration.
    do_reset();
    step(4'b1111, 1'b0, 4'b0001, 1'b0);
    step(4'b0000, 1'b0, 4'b0000, 1'b0);

    // Single pipeline write and its one-cycle pulse.
    reqs[0].rd_addr = 5'd5;
    reqs[0].data    = 32'hDEAD_BEEF;
    step(4'b0001, 1'b0, 4'b0001, 1'b0);
    step(4'b0000, 1'b0, 4'b0000, 1'b0);
    step(4'b0000, 1'b0, 4'b0000, 1'b0);

    // Round-robin among units with pointer wrap.
    step(4'b1110, 1'b0, 4'b0010, 1'b0);
    step(4'b1110, 1'b0, 4'b0100, 1'b0);
    step(4'b1110, 1'b0, 4'b1000, 1'b0);
    step(4'b1110, 1'b0, 4'b0010, 1'b0);
    step(4'b1110, 1'b0, 4'b0100, 1'b0);
    step(4'b0000, 1'b0, 4'b0000, 1'b0);

    // Starvation guard: unit 2 denied 8 cycles then preempts the pipeline.
    for (int i = 0; i < 8; i++) step(4'b0101, 1'b0, 4'b0001, 1'b0);
    step(4'b0101, 1'b0, 4'b0100, 1'b1);
    step(4'b0101, 1'b0, 4'b0001, 1'b0);
    step(4'b0000, 1'b0, 4'b0000, 1'b0);

    // Write to x0 is accepted but suppressed.
    reqs[1].rd_addr = 5'd0;
    step(4'b0010, 1'b0, 4'b0010, 1'b0);
    step(4'b0000, 1'b0, 4'b0000, 1'b0);
    reqs[1].rd_addr = 5'd11;

    // Hold blocks all grants; pipeline wins on release.
    for (int i = 0; i < 3; i++) step(4'b0011, 1'b1, 4'b0000, 1'b0);
    step(4'b0011, 1'b0, 4'b0001, 1'b0);
    step(4'b0010, 1'b0, 4'b0010, 1'b0);
    step(4'b0000, 1'b0, 4'b0000, 1'b0);

    // Reset mid-stream must clear the wait counters.
    for (int i = 0; i < 5; i++) step(4'b0101, 1'b0, 4'b0001, 1'b0);
    do_reset();
    for (int i = 0; i < 8; i++) step(4'b0101, 1'b0, 4'b0001, 1'b0);
    step(4'b0101, 1'b0, 4'b0100, 1'b1);
    step(4'b0000, 1'b0, 4'b0000, 1'b0);

    // Reset must return the round-robin pointer to 1 (it was 3 here).
    do_reset();
    step(4'b1110, 1'b0, 4'b0010, 1'b0);
    step(4'b0000, 1'b0, 4'b0000, 1'b0);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected records left unchecked", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
